seq_multiplier: RTL and testbench

SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

---
 rtl/seq_multiplier_if.sv | 21 ++
 rtl/seq_multiplier.sv | 87 ++++++++
 tb/tb_seq_multiplier.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/seq_multiplier_if.sv
// Request/result bundle between the issue logic and the shift-add multiplier.
interface seq_multiplier_if;
  logic        start;
  logic [63:0] opA;
  logic [63:0] opB;
  logic [4:0]  rdIn;
  logic        busy;
  logic        done;
  logic [63:0] product;
  logic [4:0]  rdOut;

  modport master (
    output start, opA, opB, rdIn,
    input  busy, done, product, rdOut
  );

  modport slave (
    input  start, opA, opB, rdIn,
    output busy, done, product, rdOut
  );
endinterface

// File: rtl/seq_multiplier.sv
// 64x64 -> 64 shift-and-add multiplier with a fixed 64-cycle run phase.
// The result and its destination tag are presented for one cycle on done.
module seq_multiplier (
  input  logic             clk,
  input  logic             reset,
  seq_multiplier_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e      state_q, state_d;
  logic [63:0] mcand_q, mcand_d;
  logic [63:0] mplier_q, mplier_d;
  logic [63:0] acc_q, acc_d;
  logic [5:0]  count_q, count_d;
  logic [4:0]  tag_q, tag_d;
  logic [63:0] product_q, product_d;
  logic [4:0]  rdout_q, rdout_d;
  logic [63:0] acc_sum;

  // Low 64 bits are sign-agnostic, so the partial product is added unsigned.
  assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : 64'd0);

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    count_d   = count_q;
    tag_d     = tag_q;
    product_d = product_q;
    rdout_d   = rdout_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          mcand_d  = bus.opA;
          mplier_d = bus.opB;
          acc_d    = 64'd0;
          count_d  = 6'd0;
          tag_d    = bus.rdIn;
          state_d  = StRun;
        end
      end
      StRun: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q + 6'd1;
        if (count_q == 6'd63) begin
          product_d = acc_sum;
          rdout_d   = tag_q;
          state_d   = StDone;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      mcand_q   <= 64'd0;
      mplier_q  <= 64'd0;
      acc_q     <= 64'd0;
      count_q   <= 6'd0;
      tag_q     <= 5'd0;
      product_q <= 64'd0;
      rdout_q   <= 5'd0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      count_q   <= count_d;
      tag_q     <= tag_d;
      product_q <= product_d;
      rdout_q   <= rdout_d;
    end
  end

  assign bus.busy    = (state_q == StRun);
  assign bus.done    = (state_q == StDone);
  assign bus.product = product_q;
  assign bus.rdOut   = rdout_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed and randomised checks of seq_multiplier latency, result and tag.
module tb_seq_multiplier;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_pass;

  seq_multiplier_if bus ();

  seq_multiplier dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for done after the accepting edge; returns edges elapsed (0 on timeout).
  task automatic wait_done(input logic [63:0] held, output int lat, output logic held_ok);
    lat     = 0;
    held_ok = 1'b1;
    for (int i = 1; i <= 200; i++) begin
      tick();
      if (bus.done) begin
        lat = i;
        break;
      end
      if (bus.product !== held) held_ok = 1'b0;
    end
  endtask

  // Issues one op from IDLE, checks busy, latency, result, tag, then returns to IDLE.
  task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                        input logic [4:0] rd, input logic [63:0] exp, input logic [4:0] exp_rd);
    int          lat;
    logic        held_ok;
    logic [63:0] held;
    held      = bus.product;
    bus.start = 1'b1;
    bus.opA   = a;
    bus.opB   = b;
    bus.rdIn  = rd;
    tick();
    bus.start = 1'b0;
    bus.opA   = ~a;
    bus.opB   = b + 64'd3;
    bus.rdIn  = ~rd;
    check({tag, "_busy"}, {63'd0, bus.busy}, 64'd1);
    wait_done(held, lat, held_ok);
    check({tag, "_lat"}, 64'(lat), 64'd64);
    check({tag, "_prod"}, bus.product, exp);
    check({tag, "_rd"}, {59'd0, bus.rdOut}, {59'd0, exp_rd});
    check({tag, "_excl"}, {63'd0, bus.busy}, 64'd0);
    check({tag, "_hold"}, {63'd0, held_ok}, 64'd1);
    tick();
    check({tag, "_pulse"}, {63'd0, bus.done}, 64'd0);
  endtask

  initial begin
    int          lat;
    logic        held_ok;
    logic        saw_done;
    logic [63:0] ra, rb;
    n_checks  = 0;
    n_pass    = 0;
    reset     = 1'b1;
    bus.start = 1'b1;
    bus.opA   = 64'd5;
    bus.opB   = 64'd5;
    bus.rdIn  = 5'd3;
    tick();
    tick();
    // start is held high but reset dominates
    check("rst_busy", {63'd0, bus.busy}, 64'd0);
    check("rst_done", {63'd0, bus.done}, 64'd0);
    check("rst_prod", bus.product, 64'd0);
    check("rst_rd", {59'd0, bus.rdOut}, 64'd0);
    reset     = 1'b0;
    bus.start = 1'b0;
    tick();

    run_op("basic", 64'd3, 64'd5, 5'd7, 64'd15, 5'd7);
    run_op("neg", 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd1, 64'hFFFF_FFFF_FFFF_FFFE, 5'd1);
    run_op("wrap", 64'h0000_0001_0000_0000, 64'h0000_0001_0000_0000, 5'd2, 64'd0, 5'd2);
    run_op("zero", 64'h1234, 64'd0, 5'd31, 64'd0, 5'd31);
    run_op("big", 64'h0000_0000_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF, 5'd9,
           64'hFFFF_FFFE_0000_0001, 5'd9);

    // start held continuously; operand change mid-run must not leak in
    bus.start = 1'b1;
    bus.opA   = 64'd6;
    bus.opB   = 64'd7;
    bus.rdIn  = 5'd4;
    tick();
    for (int i = 0; i < 5; i++) tick();
    bus.opA  = 64'd9;
    bus.opB  = 64'd9;
    bus.rdIn = 5'd5;
    wait_done(bus.product, lat, held_ok);
    check("b2b_lat1", 64'(lat + 5), 64'd64);
    check("b2b_prod1", bus.product, 64'd42);
    check("b2b_rd1", {59'd0, bus.rdOut}, 64'd4);
    tick();
    check("b2b_idle", {63'd0, bus.busy}, 64'd0);
    tick();
    bus.start = 1'b0;
    check("b2b_acc2", {63'd0, bus.busy}, 64'd1);
    wait_done(bus.product, lat, held_ok);
    check("b2b_lat2", 64'(lat), 64'd64);
    check("b2b_prod2", bus.product, 64'd81);
    check("b2b_rd2", {59'd0, bus.rdOut}, 64'd5);
    tick();

    // reset during RUN aborts the operation
    bus.start = 1'b1;
    bus.opA   = 64'd100;
    bus.opB   = 64'd100;
    bus.rdIn  = 5'd12;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", {63'd0, bus.busy}, 64'd0);
    check("abort_done", {63'd0, bus.done}, 64'd0);
    check("abort_prod", bus.product, 64'd0);
    check("abort_rd", {59'd0, bus.rdOut}, 64'd0);
    saw_done = 1'b0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (bus.done || bus.busy) saw_done = 1'b1;
    end
    check("abort_quiet", {63'd0, saw_done}, 64'd0);
    run_op("post_rst", 64'd4, 64'd4, 5'd6, 64'd16, 5'd6);

    for (int i = 0; i < 1000; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      run_op("rand", ra, rb, 5'(i), ra * rb, 5'(i));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
